// File: rtl/ram_init_ctrl.sv
// Memory initialiser: after reset, fills [BASE_ADDR, BASE_ADDR+MEM_SIZE) with FILL_DATA
// using sequential AXI INCR write bursts, then reports done (and error on a slave error).
module ram_init_ctrl #(
    parameter logic [31:0] MEM_SIZE    = 32'h800,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned BURST_BEATS = 16,
    parameter int unsigned ID_WIDTH    = 6,
    parameter logic [63:0] FILL_DATA   = 64'h0
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ID_WIDTH-1:0] o_awid,
    output logic [31:0]         o_awaddr,
    output logic [7:0]          o_awlen,
    output logic [2:0]          o_awsize,
    output logic [1:0]          o_awburst,
    output logic                o_awvalid,
    input  logic                i_awready,
    output logic [63:0]         o_wdata,
    output logic [7:0]          o_wstrb,
    output logic                o_wlast,
    output logic                o_wvalid,
    input  logic                i_wready,
    input  logic [ID_WIDTH-1:0] i_bid,
    input  logic [1:0]          i_bresp,
    input  logic                i_bvalid,
    output logic                o_bready,
    output logic                o_init_done,
    output logic                o_init_error,
    output logic                o_busy
);

    localparam logic [31:0] TOTAL_BEATS = MEM_SIZE >> 3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    logic [2:0]  state, state_nxt;
    logic [31:0] addr, addr_nxt;
    logic [31:0] remain, remain_nxt;
    logic [7:0]  beat, beat_nxt;
    logic [7:0]  len, len_nxt;
    logic        wlast, wlast_nxt;

    // Burst length field for the next burst given the beats still to write.
    function automatic logic [7:0] len_for(input logic [31:0] r);
        return (r > BURST_BEATS) ? 8'(BURST_BEATS - 1) : 8'(r - 32'd1);
    endfunction

    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr;
        remain_nxt = remain;
        beat_nxt   = beat;
        len_nxt    = len;
        wlast_nxt  = wlast;
        case (state)
            S_IDLE: begin
                state_nxt  = S_ADDR;
                remain_nxt = TOTAL_BEATS;
                len_nxt    = len_for(TOTAL_BEATS);
            end
            S_ADDR: begin
                if (i_awready) begin
                    state_nxt = S_DATA;
                    beat_nxt  = 8'd0;
                    wlast_nxt = (len == 8'd0);
                end
            end
            S_DATA: begin
                if (i_wready) begin
                    if (wlast) begin
                        state_nxt  = S_RESP;
                        remain_nxt = remain - (32'(len) + 32'd1);
                        wlast_nxt  = 1'b0;
                    end else begin
                        beat_nxt  = 8'(beat + 8'd1);
                        wlast_nxt = (8'(beat + 8'd1) == len);
                    end
                end
            end
            S_RESP: begin
                // Bit 1 of BRESP flags SLVERR/DECERR; OKAY and EXOKAY both count as success.
                if (i_bvalid) begin
                    if (i_bresp[1]) begin
                        state_nxt = S_ERROR;
                    end else if (remain == 32'd0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ADDR;
                        addr_nxt  = addr + ((32'(len) + 32'd1) << 3);
                        len_nxt   = len_for(remain);
                    end
                end
            end
            S_DONE:  state_nxt = S_DONE;
            S_ERROR: state_nxt = S_ERROR;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, datapath and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            addr         <= BASE_ADDR;
            remain       <= 32'd0;
            beat         <= 8'd0;
            len          <= 8'd0;
            wlast        <= 1'b0;
            o_awvalid    <= 1'b0;
            o_wvalid     <= 1'b0;
            o_bready     <= 1'b0;
            o_busy       <= 1'b0;
            o_init_done  <= 1'b0;
            o_init_error <= 1'b0;
        end else begin
            state        <= state_nxt;
            addr         <= addr_nxt;
            remain       <= remain_nxt;
            beat         <= beat_nxt;
            len          <= len_nxt;
            wlast        <= wlast_nxt;
            o_awvalid    <= (state_nxt == S_ADDR);
            o_wvalid     <= (state_nxt == S_DATA);
            o_bready     <= (state_nxt == S_RESP);
            o_busy       <= (state_nxt == S_ADDR) || (state_nxt == S_DATA) || (state_nxt == S_RESP);
            o_init_done  <= (state_nxt == S_DONE) || (state_nxt == S_ERROR);
            o_init_error <= (state_nxt == S_ERROR);
        end
    end

    assign o_awaddr  = addr;
    assign o_awlen   = len;
    assign o_wlast   = wlast;
    assign o_awid    = '0;
    assign o_awsize  = 3'd3;
    assign o_awburst = 2'b01;
    assign o_wdata   = FILL_DATA;
    assign o_wstrb   = 8'hFF;

    // Response ID and the EXOKAY bit carry no meaning for this master.
    logic unused_resp;
    assign unused_resp = ^{i_bid, i_bresp[0]};

endmodule

// File: tb/tb_ram_init_ctrl.sv
// Directed bench for ram_init_ctrl: default fill, backpressure, slave error, EXOKAY,
// mid-burst reset and a short final burst on a second instance.
module tb_ram_init_ctrl;

    localparam logic [63:0] FILL_A = 64'h0;
    localparam logic [63:0] FILL_B = 64'hDEAD_BEEF_0123_4567;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: default parameters
    logic        rst;
    logic [5:0]  a_awid, a_bid;
    logic [31:0] a_awaddr;
    logic [7:0]  a_awlen, a_wstrb;
    logic [2:0]  a_awsize;
    logic [1:0]  a_awburst, a_bresp;
    logic        a_awvalid, a_awready, a_wlast, a_wvalid, a_wready, a_bvalid, a_bready;
    logic [63:0] a_wdata;
    logic        a_done, a_error, a_busy;

    // Instance B: 17 beats, nonzero base and fill
    logic        b_rst;
    logic [5:0]  b_awid, b_bid;
    logic [31:0] b_awaddr;
    logic [7:0]  b_awlen, b_wstrb;
    logic [2:0]  b_awsize;
    logic [1:0]  b_awburst, b_bresp;
    logic        b_awvalid, b_awready, b_wlast, b_wvalid, b_wready, b_bvalid, b_bready;
    logic [63:0] b_wdata;
    logic        b_done, b_error, b_busy;

    ram_init_ctrl dut_a (
        .clk(clk), .rst(rst),
        .o_awid(a_awid), .o_awaddr(a_awaddr), .o_awlen(a_awlen), .o_awsize(a_awsize),
        .o_awburst(a_awburst), .o_awvalid(a_awvalid), .i_awready(a_awready),
        .o_wdata(a_wdata), .o_wstrb(a_wstrb), .o_wlast(a_wlast), .o_wvalid(a_wvalid),
        .i_wready(a_wready), .i_bid(a_bid), .i_bresp(a_bresp), .i_bvalid(a_bvalid),
        .o_bready(a_bready), .o_init_done(a_done), .o_init_error(a_error), .o_busy(a_busy)
    );

    ram_init_ctrl #(
        .MEM_SIZE(32'h88), .BASE_ADDR(32'h0000_1000), .BURST_BEATS(16),
        .ID_WIDTH(6), .FILL_DATA(FILL_B)
    ) dut_b (
        .clk(clk), .rst(b_rst),
        .o_awid(b_awid), .o_awaddr(b_awaddr), .o_awlen(b_awlen), .o_awsize(b_awsize),
        .o_awburst(b_awburst), .o_awvalid(b_awvalid), .i_awready(b_awready),
        .o_wdata(b_wdata), .o_wstrb(b_wstrb), .o_wlast(b_wlast), .o_wvalid(b_wvalid),
        .i_wready(b_wready), .i_bid(b_bid), .i_bresp(b_bresp), .i_bvalid(b_bvalid),
        .o_bready(b_bready), .o_init_done(b_done), .o_init_error(b_error), .o_busy(b_busy)
    );

    // Slave-model observations for instance A
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    int          beat_q[$];
    int n_aw, n_b, beats_total, wlast_err, data_err, stab_err, proto_err;
    int done_cyc, last_b_cyc;
    bit timed_out, aborted;

    task automatic slave_run(input int aw_stall, input bit w_toggle, input int bad_burst,
                             input logic [1:0] ok_resp, input int abort_burst, input int abort_beat);
        int  stall_cnt = aw_stall;
        int  beat = 0;
        int  cur_len = 0;
        bit  b_pend = 1'b0, aw_out = 1'b0, aw_hold = 1'b0, w_hold = 1'b0, wtog = 1'b0, wl_hs;
        logic [31:0] h_addr = '0;
        logic [7:0]  h_len = '0;
        logic        h_last = 1'b0;
        aw_addr_q.delete(); aw_len_q.delete(); beat_q.delete();
        n_aw = 0; n_b = 0; beats_total = 0; wlast_err = 0; data_err = 0; stab_err = 0;
        proto_err = 0; done_cyc = -1; last_b_cyc = -1; timed_out = 1'b0; aborted = 1'b0;
        a_awready = 1'b0; a_wready = 1'b0; a_bvalid = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            if (a_done) begin
                done_cyc = cyc;
                break;
            end
            if (aw_hold && (a_awvalid !== 1'b1 || a_awaddr !== h_addr || a_awlen !== h_len)) stab_err++;
            if (w_hold && (a_wvalid !== 1'b1 || a_wlast !== h_last || a_wdata !== FILL_A)) stab_err++;
            if ((a_wvalid && !aw_out) || (a_awvalid && aw_out) || (a_bready && !b_pend)) proto_err++;
            if (a_busy !== 1'b1 || a_error !== 1'b0) proto_err++;
            a_awready = 1'b0;
            if (a_awvalid) begin
                if (stall_cnt > 0) stall_cnt--;
                else a_awready = 1'b1;
            end
            wtog = !wtog;
            a_wready = w_toggle ? wtog : 1'b1;
            a_bvalid = b_pend;
            a_bresp  = (n_b + 1 == bad_burst) ? 2'b10 : ok_resp;
            wl_hs = 1'b0;
            if (a_awvalid && a_awready) begin
                aw_addr_q.push_back(a_awaddr);
                aw_len_q.push_back(a_awlen);
                if (a_awsize !== 3'd3 || a_awburst !== 2'b01 || a_awid !== 6'd0) data_err++;
                n_aw++; aw_out = 1'b1; cur_len = int'(a_awlen); beat = 0; stall_cnt = aw_stall;
            end
            aw_hold = a_awvalid && !a_awready;
            h_addr = a_awaddr; h_len = a_awlen;
            if (a_wvalid && a_wready) begin
                if (a_wdata !== FILL_A || a_wstrb !== 8'hFF) data_err++;
                if (a_wlast !== (beat == cur_len)) wlast_err++;
                beat++; beats_total++;
                if (a_wlast) begin
                    beat_q.push_back(beat);
                    wl_hs = 1'b1;
                end
                if (abort_burst != 0 && n_aw == abort_burst && beat == abort_beat) begin
                    aborted = 1'b1;
                    return;
                end
            end
            w_hold = a_wvalid && !a_wready;
            h_last = a_wlast;
            if (a_bvalid && a_bready) begin
                n_b++; last_b_cyc = cyc; b_pend = 1'b0; aw_out = 1'b0;
            end
            if (wl_hs) b_pend = 1'b1;
        end
        if (done_cyc < 0) timed_out = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1; a_awready = 1'b0; a_wready = 1'b0; a_bvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_awvalid, a_wvalid, a_wlast, a_bready, a_done, a_error, a_busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {a_awvalid, a_wvalid, a_wlast, a_bready, a_done, a_error, a_busy});
        end
        checks++;
        if (a_awaddr !== 32'h0) begin
            errors++; $display("FAIL reset_addr: got %h expected 00000000", a_awaddr);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({a_awvalid, a_busy, a_wvalid} !== 3'b110) begin
            errors++; $display("FAIL start_addr_phase: got %b expected 110", {a_awvalid, a_busy, a_wvalid});
        end
        checks++;
        if (a_awaddr !== 32'h0 || a_awlen !== 8'd15) begin
            errors++; $display("FAIL first_aw: got %h/%0d expected 00000000/15", a_awaddr, a_awlen);
        end
    endtask

    task automatic test_full_fill();
        slave_run(0, 1'b0, 0, 2'b00, 0, 0);
        checks++;
        if (timed_out || n_aw != 16) begin
            errors++; $display("FAIL full_aw_count: got %0d (timeout %0d) expected 16", n_aw, timed_out);
        end
        for (int i = 0; i < aw_addr_q.size(); i++) begin
            checks++;
            if (aw_addr_q[i] !== 32'(i * 128) || aw_len_q[i] !== 8'd15) begin
                errors++;
                $display("FAIL full_aw_%0d: got %h/%0d expected %h/15", i, aw_addr_q[i], aw_len_q[i], 32'(i * 128));
            end
        end
        checks++;
        if (beats_total != 256 || wlast_err != 0 || data_err != 0) begin
            errors++;
            $display("FAIL full_beats: got beats %0d wlast_err %0d data_err %0d expected 256/0/0",
                     beats_total, wlast_err, data_err);
        end
        checks++;
        if (proto_err != 0) begin
            errors++; $display("FAIL full_protocol: got %0d violations expected 0", proto_err);
        end
        checks++;
        if (done_cyc != last_b_cyc + 1 || n_b != 16) begin
            errors++;
            $display("FAIL full_done_timing: got done cyc %0d last B cyc %0d (B=%0d) expected one after, 16 B",
                     done_cyc, last_b_cyc, n_b);
        end
        a_bvalid = 1'b1; a_awready = 1'b1; a_wready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_awvalid, a_wvalid, a_bready, a_busy, a_done, a_error} !== 6'b000010) begin
            errors++;
            $display("FAIL done_terminal: got %b expected 000010",
                     {a_awvalid, a_wvalid, a_bready, a_busy, a_done, a_error});
        end
        a_bvalid = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        slave_run(5, 1'b1, 0, 2'b00, 0, 0);
        checks++;
        if (timed_out || n_aw != 16 || beat_q.size() != 16) begin
            errors++;
            $display("FAIL bp_bursts: got %0d AW %0d bursts (timeout %0d) expected 16/16",
                     n_aw, beat_q.size(), timed_out);
        end
        for (int i = 0; i < beat_q.size(); i++) begin
            checks++;
            if (beat_q[i] != 16) begin
                errors++; $display("FAIL bp_beats_%0d: got %0d expected 16", i, beat_q[i]);
            end
        end
        checks++;
        if (stab_err != 0) begin
            errors++; $display("FAIL bp_stability: got %0d changes expected 0", stab_err);
        end
        checks++;
        if (wlast_err != 0 || data_err != 0 || proto_err != 0) begin
            errors++;
            $display("FAIL bp_protocol: got wlast %0d data %0d proto %0d expected 0/0/0",
                     wlast_err, data_err, proto_err);
        end
    endtask

    task automatic test_error();
        int extra_aw = 0;
        do_reset();
        slave_run(0, 1'b0, 3, 2'b00, 0, 0);
        checks++;
        if (timed_out || n_aw != 3 || n_b != 3) begin
            errors++; $display("FAIL err_bursts: got %0d AW %0d B expected 3/3", n_aw, n_b);
        end
        a_awready = 1'b1; a_wready = 1'b1; a_bvalid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (a_awvalid || a_wvalid || a_bready) extra_aw++;
        end
        checks++;
        if (extra_aw != 0) begin
            errors++; $display("FAIL err_no_more_traffic: got %0d active cycles expected 0", extra_aw);
        end
        checks++;
        if ({a_done, a_error, a_busy} !== 3'b110) begin
            errors++; $display("FAIL err_status: got %b expected 110", {a_done, a_error, a_busy});
        end
    endtask

    task automatic test_exokay();
        do_reset();
        slave_run(0, 1'b0, 0, 2'b01, 0, 0);
        checks++;
        if (timed_out || n_aw != 16 || {a_done, a_error, a_busy} !== 3'b100) begin
            errors++;
            $display("FAIL exokay: got %0d AW status %b expected 16 AW status 100",
                     n_aw, {a_done, a_error, a_busy});
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        slave_run(0, 1'b0, 0, 2'b00, 2, 7);
        checks++;
        if (!aborted || n_aw != 2) begin
            errors++; $display("FAIL midrst_reach: got aborted %0d AW %0d expected 1/2", aborted, n_aw);
        end
        @(posedge clk); #1;
        rst = 1'b1; a_awready = 1'b0; a_wready = 1'b0; a_bvalid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({a_awvalid, a_wvalid, a_bready, a_done, a_error, a_busy} !== 6'b0) begin
            errors++;
            $display("FAIL midrst_abort: got %b expected 000000",
                     {a_awvalid, a_wvalid, a_bready, a_done, a_error, a_busy});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_awvalid !== 1'b1 || a_awaddr !== 32'h0 || a_awlen !== 8'd15) begin
            errors++;
            $display("FAIL midrst_restart: got valid %0d addr %h len %0d expected 1/00000000/15",
                     a_awvalid, a_awaddr, a_awlen);
        end
        slave_run(0, 1'b0, 0, 2'b00, 0, 0);
        checks++;
        if (timed_out || n_aw != 16 || beats_total != 256 || a_error !== 1'b0) begin
            errors++;
            $display("FAIL midrst_refill: got %0d AW %0d beats error %0d expected 16/256/0",
                     n_aw, beats_total, a_error);
        end
    endtask

    task automatic test_partial();
        logic [31:0] addrs[$];
        logic [7:0]  lens[$];
        int beats1 = 0, beats2 = 0, dbad = 0;
        bit last2 = 1'b0, pend = 1'b0, seen_done = 1'b0, hs_last;
        b_rst = 1'b1;
        @(posedge clk); #1;
        b_rst = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(posedge clk); #1;
            if (b_done) begin
                seen_done = 1'b1;
                break;
            end
            b_awready = 1'b1; b_wready = 1'b1; b_bvalid = pend; b_bresp = 2'b00;
            if (b_awvalid) begin
                addrs.push_back(b_awaddr);
                lens.push_back(b_awlen);
                if (b_awsize !== 3'd3 || b_awburst !== 2'b01 || b_awid !== 6'd0) dbad++;
            end
            hs_last = b_wvalid && b_wlast;
            if (b_wvalid) begin
                if (b_wdata !== FILL_B || b_wstrb !== 8'hFF) dbad++;
                if (addrs.size() == 1) beats1++;
                else beats2++;
                if (addrs.size() == 2) last2 = b_wlast;
            end
            if (b_bvalid && b_bready) pend = 1'b0;
            if (hs_last) pend = 1'b1;
        end
        checks++;
        if (!seen_done || addrs.size() != 2) begin
            errors++; $display("FAIL part_count: got %0d AW done %0d expected 2/1", addrs.size(), seen_done);
        end
        if (addrs.size() >= 2) begin
            checks++;
            if (addrs[0] !== 32'h1000 || lens[0] !== 8'd15) begin
                errors++; $display("FAIL part_aw0: got %h/%0d expected 00001000/15", addrs[0], lens[0]);
            end
            checks++;
            if (addrs[1] !== 32'h1080 || lens[1] !== 8'd0) begin
                errors++; $display("FAIL part_aw1: got %h/%0d expected 00001080/0", addrs[1], lens[1]);
            end
        end
        checks++;
        if (beats1 != 16 || beats2 != 1 || last2 !== 1'b1) begin
            errors++;
            $display("FAIL part_beats: got %0d/%0d last %0d expected 16/1/1", beats1, beats2, last2);
        end
        checks++;
        if (dbad != 0 || {b_done, b_error, b_busy} !== 3'b100) begin
            errors++;
            $display("FAIL part_data_status: got bad %0d status %b expected 0/100", dbad, {b_done, b_error, b_busy});
        end
    endtask

    initial begin
        rst = 1'b1; a_awready = 1'b0; a_wready = 1'b0; a_bvalid = 1'b0; a_bresp = 2'b00; a_bid = 6'h2A;
        b_rst = 1'b1; b_awready = 1'b0; b_wready = 1'b0; b_bvalid = 1'b0; b_bresp = 2'b00; b_bid = 6'h15;
        test_reset();
        test_full_fill();
        test_backpressure();
        test_error();
        test_exokay();
        test_mid_reset();
        test_partial();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
